demux_route_sched: RTL and testbench
====================================

// Module: demux_route_sched
// PURPOSE
//  Scheduler/controller for the 1-to-2 DeMultiplexer datapath (A_in, Select -> outB/outC).
//  - Accepts a stream of DATA_W-bit words on a valid/ready input.
//  - Decides the destination of each word (B or C), then drives the demux data (A_in) and Select.
//  - Presents per-destination valid, honours per-destination ready backpressure and counts deliveries.
//  - Sits between an upstream producer and the DeMultiplexer instance plus its two consumers.
// PARAMETERS
//  DATA_W     2  width of each data word (matches demux A_in)
//  BURST_LEN  4  words routed to one output before round-robin switches (>=1)
//  CNT_W      8  width of delivered-word counters b_count/c_count
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  in_data    in   DATA_W  input word
//  in_valid   in   1       in_data valid
//  in_ready   out  1       block can accept in_data this cycle
//  in_dest    in   1       destination tag in tag mode: 0=B, 1=C
//  mode       in   1       0=round-robin burst routing, 1=tag routing (in_dest)
//  dmx_data   out  DATA_W  to demux A_in (held word)
//  dmx_sel    out  1       to demux Select: 0=outB, 1=outC
//  b_valid    out  1       word on outB valid
//  b_ready    in   1       consumer B accepts
//  c_valid    out  1       word on outC valid
//  c_ready    in   1       consumer C accepts
//  b_count    out  CNT_W   words delivered to B (wraps)
//  c_count    out  CNT_W   words delivered to C (wraps)
// BEHAVIOUR
//  - One-entry hold register (hold_data, hold_sel, hold_valid) drives dmx_data/dmx_sel.
//  - FSM on the hold register:
//    - States: EMPTY, HOLD_B, HOLD_C.
//    - EMPTY -> HOLD_x on accept.
//    - HOLD_x -> EMPTY on transfer with no accept.
//    - HOLD_x -> HOLD_y on transfer plus accept in the same cycle.
//  - b_valid = (state==HOLD_B); c_valid = (state==HOLD_C).
//  - Transfer: b_valid&b_ready or c_valid&c_ready.
//  - in_ready = !rst & (EMPTY | transfer this cycle): combinational from b_ready/c_ready.
//  - Accept = in_valid & in_ready.
//  - Accepted word visible on dmx_data/valid the next cycle (latency 1); sustained throughput 1 word/cycle.
//  - Valid is held and data stable until transfer.
//  - A stalled output blocks all input (head-of-line blocking); the other ready is ignored.
//  - Destination at accept:
//    - mode=1: hold_sel <= in_dest.
//    - mode=0: hold_sel <= rr_sel.
//  - Round-robin pointer:
//    - rr_sel and burst_cnt (0..BURST_LEN-1) advance only on accepts in mode=0.
//    - When burst_cnt==BURST_LEN-1 on an accept: burst_cnt <= 0 and rr_sel toggles.
//    - Otherwise burst_cnt +1.
//    - In mode=1, rr_sel and burst_cnt hold their values.
//    - A change of mode takes effect on the next accepted word; it never alters the held word.
//  - Counters: b_count +1 on B transfer, c_count +1 on C transfer.
//    - Modulo 2^CNT_W (all-ones wraps to 0).
//  - Reset values:
//    - EMPTY, dmx_data=0, dmx_sel=0, b_valid=c_valid=0, in_ready=0 while rst=1.
//    - rr_sel=0 (B), burst_cnt=0, b_count=c_count=0.
//  - Reset mid-operation: the held word is discarded without transfer; the next word after reset routes to B (mode=0).
//  - BURST_LEN=1: mode=0 alternates B,C,B,C per word.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_valid=1.
//     -> in_ready=0, b/c_valid=0, counts 0; in_ready=1 the first cycle after release.
//  2. mode=0, b_ready=c_ready=1, 8 back-to-back words 0,1,2,3,0,1,2,3.
//     -> first 4 on B, next 4 on C, one per cycle, each 1 cycle after accept; b_count=4, c_count=4.
//  3. mode=1, in_dest 0,1,1,0 with data 3,2,1,0.
//     -> B gets 3 then 0; C gets 2 then 1; dmx_sel follows 0,1,1,0.
//  4. Word 2 held for B with b_ready=0 for 5 cycles, c_ready=1.
//     -> in_ready=0, dmx_data=2 and b_valid stable; b_ready=1 -> transfer, in_ready=1 the same cycle.
//  5. mode=0, rst pulsed after 2 accepted words (one held).
//     -> held word dropped, b_count unchanged; next 4 words go to B.
//  6. 256 transfers to B (CNT_W=8) -> b_count wraps to 0; c_count=0.

Source files
------------

// File: rtl/demux_route_sched.sv
// Scheduler for a 1-to-2 demux: a one-word hold register picks B or C (round-robin bursts or tag),
// drives A_in/Select, handshakes with per-destination ready and counts deliveries.
module demux_route_sched #(
  parameter int DATA_W    = 2,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dest,
  input  logic              mode,
  output logic [DATA_W-1:0] dmx_data,
  output logic              dmx_sel,
  output logic              b_valid,
  input  logic              b_ready,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [CNT_W-1:0]  b_count,
  output logic [CNT_W-1:0]  c_count
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {EMPTY, HOLD_B, HOLD_C} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] hold_data_reg;
  logic              hold_sel_reg;
  logic              rr_sel_reg;
  logic [BW-1:0]     burst_cnt_reg;
  logic [CNT_W-1:0]  b_count_reg, c_count_reg;

  logic b_xfer, c_xfer, transfer, accept, dest;

  // Ready looks through the downstream handshake so a full register can refill every cycle.
  always_comb begin
    b_xfer   = (state_reg == HOLD_B) & b_ready;
    c_xfer   = (state_reg == HOLD_C) & c_ready;
    transfer = b_xfer | c_xfer;
    in_ready = !rst & ((state_reg == EMPTY) | transfer);
    accept   = in_valid & in_ready;
    dest     = mode ? in_dest : rr_sel_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (accept)        state_next = dest ? HOLD_C : HOLD_B;
    else if (transfer) state_next = EMPTY;
  end

  always_comb begin
    b_valid  = (state_reg == HOLD_B);
    c_valid  = (state_reg == HOLD_C);
    dmx_data = hold_data_reg;
    dmx_sel  = hold_sel_reg;
    b_count  = b_count_reg;
    c_count  = c_count_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_reg <= '0;
      hold_sel_reg  <= 1'b0;
    end else if (accept) begin
      hold_data_reg <= in_data;
      hold_sel_reg  <= dest;
    end
  end

  // The round-robin pointer only moves on words it actually routed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_sel_reg    <= 1'b0;
      burst_cnt_reg <= '0;
    end else if (accept && !mode) begin
      if (burst_cnt_reg == BURST_LAST) begin
        burst_cnt_reg <= '0;
        rr_sel_reg    <= ~rr_sel_reg;
      end else begin
        burst_cnt_reg <= burst_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_count_reg <= '0;
      c_count_reg <= '0;
    end else begin
      if (b_xfer) b_count_reg <= b_count_reg + 1'b1;
      if (c_xfer) c_count_reg <= c_count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_route_sched.sv
// Bench for demux_route_sched: directed scenarios plus random traffic, all checked each cycle
// against a word-level model (one slot, accept index -> burst destination, delivery logs).
module tb_demux_route_sched;
  localparam int DW = 2;
  localparam int BL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_dest = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] dmx_data;
  logic          dmx_sel;
  logic          b_valid;
  logic          b_ready = 1'b0;
  logic          c_valid;
  logic          c_ready = 1'b0;
  logic [CW-1:0] b_count;
  logic [CW-1:0] c_count;

  demux_route_sched #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .mode(mode), .dmx_data(dmx_data), .dmx_sel(dmx_sel),
    .b_valid(b_valid), .b_ready(b_ready), .c_valid(c_valid), .c_ready(c_ready),
    .b_count(b_count), .c_count(c_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: slot contents, number of mode-0 accepts since reset, delivery counts and logs.
  bit m_init = 0;
  bit m_valid = 0;
  int m_data = 0, m_sel = 0, m_n = 0, m_bc = 0, m_cc = 0;
  int qb[$];
  int qc[$];

  always @(negedge clk) begin
    int exp_rdy, xfer, acc;
    xfer    = (m_valid && (m_sel ? c_ready : b_ready)) ? 1 : 0;
    exp_rdy = (!rst && (!m_valid || xfer)) ? 1 : 0;
    acc     = (in_valid && exp_rdy) ? 1 : 0;
    if (m_init) begin
      chk("in_ready", int'(in_ready), exp_rdy);
      chk("b_valid", int'(b_valid), (m_valid && m_sel == 0) ? 1 : 0);
      chk("c_valid", int'(c_valid), (m_valid && m_sel == 1) ? 1 : 0);
      chk("dmx_data", int'(dmx_data), m_data);
      chk("dmx_sel", int'(dmx_sel), m_sel);
      chk("b_count", int'(b_count), m_bc);
      chk("c_count", int'(c_count), m_cc);
    end
    if (rst) begin
      m_init = 1; m_valid = 0; m_data = 0; m_sel = 0; m_n = 0; m_bc = 0; m_cc = 0;
    end else if (m_init) begin
      if (xfer) begin
        if (m_sel == 1) begin m_cc = (m_cc + 1) % (1 << CW); qc.push_back(m_data); end
        else            begin m_bc = (m_bc + 1) % (1 << CW); qb.push_back(m_data); end
      end
      if (acc) begin
        m_data = int'(in_data);
        if (mode) m_sel = int'(in_dest);
        else begin m_sel = (m_n / BL) % 2; m_n++; end
        m_valid = 1;
      end else if (xfer) begin
        m_valid = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int d3[4] = '{3, 2, 1, 0};
  int s3[4] = '{0, 1, 1, 0};

  initial begin
    // Reset held two cycles with a word offered.
    rst = 1; in_valid = 1; in_data = 2'd1; b_ready = 1; c_ready = 1;
    cyc();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_b_valid", int'(b_valid), 0);
    chk("rst_b_count", int'(b_count), 0);
    cyc();
    rst = 0; in_valid = 0;
    #1;
    chk("rel_in_ready", int'(in_ready), 1);

    // Round-robin: 4 to B, then 4 to C.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_data = DW'(i % 4);
      cyc();
    end
    in_valid = 0;
    cyc(); cyc();
    chk("t2_b_count", int'(b_count), 4);
    chk("t2_c_count", int'(c_count), 4);
    chk("t2_qb_n", qb.size(), 4);
    chk("t2_qc_n", qc.size(), 4);
    for (int i = 0; i < 4 && i < qb.size() && i < qc.size(); i++) begin
      chk("t2_qb", qb[i], i);
      chk("t2_qc", qc[i], i);
    end

    // Tag routing.
    qb.delete(); qc.delete();
    mode = 1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_data = DW'(d3[k]); in_dest = s3[k][0];
      cyc();
      chk("t3_sel", int'(dmx_sel), s3[k]);
      chk("t3_data", int'(dmx_data), d3[k]);
    end
    in_valid = 0;
    cyc(); cyc();
    chk("t3_qb_n", qb.size(), 2);
    chk("t3_qc_n", qc.size(), 2);
    if (qb.size() == 2) begin chk("t3_qb0", qb[0], 3); chk("t3_qb1", qb[1], 0); end
    if (qc.size() == 2) begin chk("t3_qc0", qc[0], 2); chk("t3_qc1", qc[1], 1); end

    // B stalled for 5 cycles with the next word waiting.
    b_ready = 0; c_ready = 1;
    in_valid = 1; in_data = 2'd2; in_dest = 0;
    cyc();
    in_data = 2'd1; in_dest = 1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_in_ready", int'(in_ready), 0);
      chk("t4_data", int'(dmx_data), 2);
      chk("t4_b_valid", int'(b_valid), 1);
      cyc();
    end
    b_ready = 1;
    #1;
    chk("t4_release_ready", int'(in_ready), 1);
    cyc();
    chk("t4_next_sel", int'(dmx_sel), 1);
    chk("t4_next_data", int'(dmx_data), 1);
    in_valid = 0;
    cyc();
    chk("t4_b_count", int'(b_count), 7);
    chk("t4_c_count", int'(c_count), 7);

    // Reset with a word still held.
    mode = 0; qb.delete(); qc.delete();
    in_valid = 1; in_data = 2'd1; cyc();
    in_data = 2'd2; cyc();
    in_valid = 0; rst = 1; cyc();
    rst = 0;
    chk("t5_b_count_rst", int'(b_count), 0);
    chk("t5_dropped", qb.size(), 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = DW'(i); cyc();
    end
    in_valid = 0;
    cyc(); cyc();
    chk("t5_qb_n", qb.size(), 5);
    chk("t5_qc_n", qc.size(), 0);
    chk("t5_b_count", int'(b_count), 4);

    // Counter wrap after 256 B deliveries.
    rst = 1; cyc(); rst = 0;
    mode = 1; in_dest = 0; qb.delete(); qc.delete();
    for (int i = 0; i < 256; i++) begin
      in_valid = 1; in_data = DW'($urandom); cyc();
    end
    in_valid = 0;
    cyc(); cyc();
    chk("t6_b_count", int'(b_count), 0);
    chk("t6_c_count", int'(c_count), 0);
    chk("t6_qb_n", qb.size(), 256);

    // Random traffic, mode flips, backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom);
      in_dest  = 1'($urandom);
      b_ready  = ($urandom_range(0, 3) != 0);
      c_ready  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      cyc();
    end
    rst = 0; in_valid = 0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
